// File: rtl/clk_start_seq.sv
// clk_start_seq
// ---------------------------------------------------------------------------
// Clock-start and reset sequencer placed between the MMCM and the functional
// tops. The MMCM lock flag is synchronised and must stay high for
// LOCK_STABLE cycles. Only then are NUM_CH clock domains released one after
// another, STAGGER cycles apart. Each channel gets a BUFGCE enable and an
// active-high reset that is held for RST_HOLD cycles after its enable rises.
// Lock loss after release shuts every channel down and sets a sticky flag.
// A soft_rst request re-runs the whole sequence and clears that flag.
//
// Ports
//   clk        free-running board clock (never the gated one)
//   rst_n      asynchronous active-low reset
//   locked     MMCM lock, asynchronous to clk
//   soft_rst   synchronous active-high re-sequence request
//   ch_en      per-channel BUFGCE CE (registered)
//   ch_rst     per-channel active-high downstream reset (registered)
//   ready      all channels enabled and out of reset (registered)
//   lock_lost  sticky: lock dropped after release began (registered)
//   state      FSM state for debug: 0 WAIT_LOCK, 1 STABLE, 2 RELEASE, 3 RUN
module clk_start_seq #(
    parameter int NUM_CH      = 2,
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_STABLE = 8,
    parameter int STAGGER     = 4,
    parameter int RST_HOLD    = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              locked,
    input  logic              soft_rst,
    output logic [NUM_CH-1:0] ch_en,
    output logic [NUM_CH-1:0] ch_rst,
    output logic              ready,
    output logic              lock_lost,
    output logic [1:0]        state
);

    // Value of the release counter on the edge that enters RUN.
    localparam int LAST    = (NUM_CH - 1) * STAGGER + RST_HOLD;
    localparam int CNT_MAX = (LOCK_STABLE > LAST) ? LOCK_STABLE : LAST;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] STABLE_END  = CW'(LOCK_STABLE - 1);
    localparam logic [CW-1:0] RELEASE_END = CW'(LAST);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [NUM_CH-1:0]      ch_en_q, ch_en_d;
    logic [NUM_CH-1:0]      ch_rst_q, ch_rst_d;
    logic                   ready_q, ready_d;
    logic                   lock_lost_q, lock_lost_d;
    logic                   lock_s;
    logic                   lost_evt;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], locked};
    assign lock_s = sync_q[SYNC_STAGES-1];

    // Lock loss only counts once channels may already be running.
    assign lost_evt = !lock_s && ((state_q == RELEASE) || (state_q == RUN));

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= WAIT_LOCK;
            cnt_q       <= '0;
            sync_q      <= '0;
            ch_en_q     <= '0;
            ch_rst_q    <= '1;
            ready_q     <= 1'b0;
            lock_lost_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sync_q      <= sync_d;
            ch_en_q     <= ch_en_d;
            ch_rst_q    <= ch_rst_d;
            ready_q     <= ready_d;
            lock_lost_q <= lock_lost_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            WAIT_LOCK: begin
                if (lock_s) state_d = STABLE;
            end
            STABLE: begin
                if (!lock_s)                  state_d = WAIT_LOCK;
                else if (cnt_q == STABLE_END) state_d = RELEASE;
                else                          cnt_d   = cnt_q + 1'b1;
            end
            RELEASE: begin
                if (!lock_s)                          state_d = WAIT_LOCK;
                else if (cnt_q + 1'b1 == RELEASE_END) state_d = RUN;
                else                                  cnt_d   = cnt_q + 1'b1;
            end
            RUN: begin
                if (!lock_s) state_d = WAIT_LOCK;
            end
            default: state_d = WAIT_LOCK;
        endcase
        if (soft_rst) state_d = WAIT_LOCK;
        // The shared counter restarts from zero in every new state.
        if (state_d != state_q) cnt_d = '0;
    end

    // ---------------- output logic ----------------
    // Outputs are computed from the next state/count so that the registered
    // value changes on the same edge that moves the FSM.
    always_comb begin
        ch_en_d  = '0;
        ch_rst_d = '1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (state_d == RUN) begin
                ch_en_d[i]  = 1'b1;
                ch_rst_d[i] = 1'b0;
            end else if (state_d == RELEASE) begin
                ch_en_d[i]  = (cnt_d >= CW'(i * STAGGER));
                ch_rst_d[i] = !(cnt_d >= CW'(i * STAGGER + RST_HOLD));
            end
        end
        ready_d = (state_d == RUN);
        // Setting on lock loss takes priority over the soft_rst clear.
        if (lost_evt)      lock_lost_d = 1'b1;
        else if (soft_rst) lock_lost_d = 1'b0;
        else               lock_lost_d = lock_lost_q;
    end

    assign ch_en     = ch_en_q;
    assign ch_rst    = ch_rst_q;
    assign ready     = ready_q;
    assign lock_lost = lock_lost_q;
    assign state     = state_q;

endmodule

// File: tb/tb_clk_start_seq.sv
// Bench for clk_start_seq. Two instances share clk/rst_n/soft_rst: u_dut
// with default parameters, u_dut4 with NUM_CH=4, STAGGER=1, RST_HOLD=1.
// Each output change is an event that is matched against the expected
// queue entry (snapshot value plus the edge on which it must occur).
module tb_clk_start_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       locked;
    logic       locked4;
    logic       soft_rst;

    logic [1:0] ch_en, ch_rst, state;
    logic       ready, lock_lost;
    logic [3:0] ch_en4, ch_rst4;
    logic [1:0] state4;
    logic       ready4, lock_lost4;

    int cyc    = 0;
    int base   = 0;
    int checks = 0;
    int errors = 0;

    // snapshot = {state, lock_lost, ready, ch_rst, ch_en}
    localparam logic [7:0]  RST0 = {2'd0, 1'b0, 1'b0, 2'b11, 2'b00};
    localparam logic [11:0] RST4 = {2'd0, 1'b0, 1'b0, 4'b1111, 4'b0000};

    logic [7:0]  exp_q[$];
    int          exp_cyc_q[$];
    logic [11:0] exp4_q[$];
    int          exp4_cyc_q[$];

    logic [7:0]  prev0 = RST0;
    logic [11:0] prev4 = RST4;

    clk_start_seq u_dut (
        .clk(clk), .rst_n(rst_n), .locked(locked), .soft_rst(soft_rst),
        .ch_en(ch_en), .ch_rst(ch_rst), .ready(ready),
        .lock_lost(lock_lost), .state(state)
    );

    clk_start_seq #(.NUM_CH(4), .STAGGER(1), .RST_HOLD(1)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .locked(locked4), .soft_rst(soft_rst),
        .ch_en(ch_en4), .ch_rst(ch_rst4), .ready(ready4),
        .lock_lost(lock_lost4), .state(state4)
    );

    // ---------------- clock / cycle count ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] s0(input logic [1:0] st, input logic ll,
                                      input logic rdy, input logic [1:0] rs,
                                      input logic [1:0] en);
        return {st, ll, rdy, rs, en};
    endfunction

    function automatic logic [11:0] s4(input logic [1:0] st, input logic rdy,
                                       input logic [3:0] rs, input logic [3:0] en);
        return {st, 1'b0, rdy, rs, en};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic push0(input int e, input logic [7:0] v);
        exp_cyc_q.push_back(base + e);
        exp_q.push_back(v);
    endtask

    task automatic push4(input int e, input logic [11:0] v);
        exp4_cyc_q.push_back(base + e);
        exp4_q.push_back(v);
    endtask

    // Default-parameter release: STABLE 3, en0 11, rst0 low 14, en1 15,
    // RUN/ready 18 edges after locked goes high (shifted by s).
    task automatic seq0(input int s, input logic ll);
        push0(s + 3,  s0(2'd1, ll, 1'b0, 2'b11, 2'b00));
        push0(s + 11, s0(2'd2, ll, 1'b0, 2'b11, 2'b01));
        push0(s + 14, s0(2'd2, ll, 1'b0, 2'b10, 2'b01));
        push0(s + 15, s0(2'd2, ll, 1'b0, 2'b10, 2'b11));
        push0(s + 18, s0(2'd3, ll, 1'b1, 2'b00, 2'b11));
    endtask

    task automatic drain(input int limit, input string name);
        int n = 0;
        while ((exp_q.size() != 0 || exp4_q.size() != 0) && n < limit) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || exp4_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d events still pending after %0d cycles, required 0",
                     name, exp_q.size() + exp4_q.size(), limit);
            exp_q.delete(); exp_cyc_q.delete();
            exp4_q.delete(); exp4_cyc_q.delete();
        end
    endtask

    // ---------------- scoreboard monitors ----------------
    always @(negedge clk) begin
        logic [7:0] cur;
        logic [7:0] v;
        int         c;
        cur = {state, lock_lost, ready, ch_rst, ch_en};
        checks++;
        if ((!ch_rst[0] && !ch_en[0]) || (!ch_rst[1] && !ch_en[1]) ||
            (ch_en[1] && !ch_en[0])) begin
            errors++;
            $display("FAIL dut_order: ch_en=%b ch_rst=%b at cycle %0d", ch_en, ch_rst, cyc);
        end
        if (cur !== prev0) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL dut_event: unexpected snapshot %b at cycle %0d, required no change",
                         cur, cyc);
            end else begin
                v = exp_q.pop_front();
                c = exp_cyc_q.pop_front();
                if (cur !== v || cyc != c) begin
                    errors++;
                    $display("FAIL dut_event: got %b at cycle %0d, required %b at cycle %0d",
                             cur, cyc, v, c);
                end
            end
        end
        prev0 = cur;
    end

    always @(negedge clk) begin
        logic [11:0] cur;
        logic [11:0] v;
        int          c;
        logic        bad;
        cur = {state4, lock_lost4, ready4, ch_rst4, ch_en4};
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (!ch_rst4[i] && !ch_en4[i]) bad = 1'b1;
            if (i > 0 && ch_en4[i] && !ch_en4[i-1]) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL dut4_order: ch_en=%b ch_rst=%b at cycle %0d", ch_en4, ch_rst4, cyc);
        end
        if (cur !== prev4) begin
            checks++;
            if (exp4_q.size() == 0) begin
                errors++;
                $display("FAIL dut4_event: unexpected snapshot %b at cycle %0d, required no change",
                         cur, cyc);
            end else begin
                v = exp4_q.pop_front();
                c = exp4_cyc_q.pop_front();
                if (cur !== v || cyc != c) begin
                    errors++;
                    $display("FAIL dut4_event: got %b at cycle %0d, required %b at cycle %0d",
                             cur, cyc, v, c);
                end
            end
        end
        prev4 = cur;
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_n    = 1'b0;
        locked   = 1'b0;
        locked4  = 1'b0;
        soft_rst = 1'b0;
        repeat (5) @(negedge clk);

        // Reset values.
        checks++;
        if ({state, lock_lost, ready, ch_rst, ch_en} !== RST0) begin
            errors++;
            $display("FAIL reset0: got %b, required %b",
                     {state, lock_lost, ready, ch_rst, ch_en}, RST0);
        end
        checks++;
        if ({state4, lock_lost4, ready4, ch_rst4, ch_en4} !== RST4) begin
            errors++;
            $display("FAIL reset4: got %b, required %b",
                     {state4, lock_lost4, ready4, ch_rst4, ch_en4}, RST4);
        end

        // Power-up release.
        rst_n  = 1'b1;
        locked = 1'b1;
        base   = cyc;
        seq0(0, 1'b0);
        drain(40, "power_up");

        // Lock loss in RUN, then full re-release with lock_lost held.
        locked = 1'b0;
        base   = cyc;
        push0(3, s0(2'd0, 1'b1, 1'b0, 2'b11, 2'b00));
        repeat (6) @(negedge clk);
        locked = 1'b1;
        base   = cyc;
        seq0(0, 1'b1);
        drain(40, "lock_loss_run");

        // soft_rst in RUN clears lock_lost; re-release one edge earlier
        // because lock_s is already high.
        soft_rst = 1'b1;
        base     = cyc;
        push0(1, s0(2'd0, 1'b0, 1'b0, 2'b11, 2'b00));
        seq0(-1, 1'b0);
        @(negedge clk);
        soft_rst = 1'b0;
        drain(40, "soft_rst_run");

        // Lock glitch in STABLE: FSM sees lock_s=0 at edge 8 with cnt=5.
        soft_rst = 1'b1;
        base     = cyc;
        push0(1, RST0);
        push0(2, s0(2'd1, 1'b0, 1'b0, 2'b11, 2'b00));
        push0(8, RST0);
        seq0(7, 1'b0);
        @(negedge clk);
        soft_rst = 1'b0;
        repeat (4) @(negedge clk);
        locked = 1'b0;
        repeat (2) @(negedge clk);
        locked = 1'b1;
        drain(50, "stable_glitch");

        // Simultaneous lock loss and soft_rst: lock_lost set wins.
        locked = 1'b0;
        base   = cyc;
        push0(3, s0(2'd0, 1'b1, 1'b0, 2'b11, 2'b00));
        repeat (2) @(negedge clk);
        soft_rst = 1'b1;
        @(negedge clk);
        soft_rst = 1'b0;
        repeat (4) @(negedge clk);
        drain(20, "simultaneous");

        // rst_n asserted mid-RELEASE with both enables on, ch_rst[1] still high.
        locked = 1'b1;
        base   = cyc;
        push0(3,  s0(2'd1, 1'b1, 1'b0, 2'b11, 2'b00));
        push0(11, s0(2'd2, 1'b1, 1'b0, 2'b11, 2'b01));
        push0(14, s0(2'd2, 1'b1, 1'b0, 2'b10, 2'b01));
        push0(15, s0(2'd2, 1'b1, 1'b0, 2'b10, 2'b11));
        repeat (15) @(negedge clk);
        @(posedge clk);
        #2;
        push0(16, RST0);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({state, lock_lost, ready, ch_rst, ch_en} !== RST0) begin
            errors++;
            $display("FAIL async_reset: got %b, required %b",
                     {state, lock_lost, ready, ch_rst, ch_en}, RST0);
        end
        locked = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        drain(10, "async_reset");
        @(negedge clk);

        // Parameter sweep: NUM_CH=4, STAGGER=1, RST_HOLD=1.
        locked4 = 1'b1;
        base    = cyc;
        push4(3,  s4(2'd1, 1'b0, 4'b1111, 4'b0000));
        push4(11, s4(2'd2, 1'b0, 4'b1111, 4'b0001));
        push4(12, s4(2'd2, 1'b0, 4'b1110, 4'b0011));
        push4(13, s4(2'd2, 1'b0, 4'b1100, 4'b0111));
        push4(14, s4(2'd2, 1'b0, 4'b1000, 4'b1111));
        push4(15, s4(2'd3, 1'b1, 4'b0000, 4'b1111));
        drain(40, "sweep4");
        repeat (5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/clk_start_seq.md
# clk_start_seq

Parametrised clock-start and reset sequencer that sits between the MMCM and the functional tops in the FPGA wrapper. It synchronises the MMCM `locked` flag and requires it to stay stable before anything is released. It then releases `NUM_CH` downstream clock domains in a staggered order, driving a BUFGCE enable plus a held active-high reset per channel. It also handles lock loss at run time and software re-sequencing, neither of which a fixed `safe_start` shift register covers.

## Interface
Parameters:
- `NUM_CH`, 2: number of released channels; range 1..8.
- `SYNC_STAGES`, 2: flops in the `locked` synchroniser; minimum 2.
- `LOCK_STABLE`, 8: consecutive cycles the synchronised lock must be high before release; minimum 1.
- `STAGGER`, 4: cycles between successive channel enables; minimum 1.
- `RST_HOLD`, 3: cycles `ch_rst[i]` stays high after `ch_en[i]` rises; minimum 1.

Ports:
- `clk`, in, 1: free-running sequencer clock (board clock, not the gated one).
- `rst_n`, in, 1: asynchronous, active-low reset.
- `locked`, in, 1: MMCM lock, asynchronous to `clk`.
- `soft_rst`, in, 1: synchronous, active-high re-sequence request; the caller provides it already synchronised.
- `ch_en`, out, `NUM_CH`: per-channel BUFGCE CE.
- `ch_rst`, out, `NUM_CH`: per-channel active-high reset for downstream tops.
- `ready`, out, 1: all channels enabled and out of reset.
- `lock_lost`, out, 1: sticky flag, set on lock loss after release.
- `state`, out, 2: current FSM state (debug).

## Operation
- `lock_s` is `locked` after `SYNC_STAGES` flops; all decisions use `lock_s`.
- FSM states and encodings: WAIT_LOCK=0, STABLE=1, RELEASE=2, RUN=3.
- **WAIT_LOCK**: `ch_en`=0, `ch_rst`=all 1. If `lock_s`=1, go to STABLE with `cnt`=0.
- **STABLE**: while `lock_s`=1, increment `cnt`.
  - `lock_s`=0 returns to WAIT_LOCK; a glitch restarts the count.
  - When `cnt`==`LOCK_STABLE`-1 with `lock_s`=1, go to RELEASE with `t`=0.
- **RELEASE**: `t` increments each cycle.
  - `ch_en[i]` is 1 from the edge on which `t` reaches i*`STAGGER`; `ch_en[0]` rises on entry.
  - `ch_rst[i]` falls on the edge where `t` reaches i*`STAGGER`+`RST_HOLD`.
  - On the edge where `t` reaches (`NUM_CH`-1)*`STAGGER`+`RST_HOLD`, go to RUN. The same edge raises `ready`.
- **RUN**: outputs hold; `ready`=1.
- **Lock loss** (`lock_s`=0 in RELEASE or RUN):
  - Next edge: all `ch_en`=0, all `ch_rst`=1, `ready`=0, state WAIT_LOCK.
  - `lock_lost` is set.
- **`soft_rst`=1** in any state:
  - Next edge: all `ch_en`=0, all `ch_rst`=1, `ready`=0, state WAIT_LOCK.
  - `lock_lost` is cleared.
- **Simultaneous lock loss and `soft_rst`**: state goes to WAIT_LOCK and `lock_lost` is set (set wins over clear).
- **Counter width**: one shared counter serves as both `cnt` and `t`. It is $clog2(max(`LOCK_STABLE`, (`NUM_CH`-1)*`STAGGER`+`RST_HOLD`)+1) bits and never wraps: it is cleared on every state change and stops at its terminal value.
- **Ordering guarantees**:
  - `ch_en` bits rise in index order and only while `lock_s`=1.
  - `ch_rst[i]` is never 0 while `ch_en[i]`=0.

## Timing
- **Reset values** (asynchronous on `rst_n`=0):
  - state WAIT_LOCK, counter 0, synchroniser flops 0.
  - `ch_en`=0, `ch_rst`=all 1, `ready`=0, `lock_lost`=0.
- **Reset release**: `rst_n` is released asynchronously; all outputs are registered, with no combinational path from inputs.
- **Input latency**: `locked` reaches `lock_s` after `SYNC_STAGES` edges; the FSM reacts on the next edge.
- **Release latency**, defaults, `locked` high and stable before edge 1:
  - `lock_s`=1 after edge 2; STABLE at edge 3.
  - `ch_en[0]`=1 at edge 11; `ch_rst[0]`=0 at edge 14.
  - `ch_en[1]`=1 at edge 15; `ch_rst[1]`=0 and `ready`=1 at edge 18.
- **Shutdown latency**:
  - `locked` falling before edge k: outputs shut down at edge k+`SYNC_STAGES`.
  - `soft_rst` sampled at edge k: outputs shut down at edge k.
- **`rst_n` mid-RELEASE**: immediate asynchronous return to reset values; no partial channel states remain.

## Test plan
- **Power-up release**: `rst_n` low for 5 cycles, then `locked`=1 held → `ch_en` 01 at edge 11, 11 at edge 15; `ch_rst` 10 at edge 14, 00 at edge 18; `ready`=1 at edge 18; `state`=3.
- **Lock glitch in STABLE**: `locked` low for 2 cycles when `cnt`=5 → state returns to 0 then 1, `cnt` restarts; `ch_en[0]` rises only after 8 further stable cycles.
- **Lock loss in RUN**: drop `locked` → `SYNC_STAGES` edges later `ch_en`=00, `ch_rst`=11, `ready`=0, `lock_lost`=1; re-lock runs the full sequence again while `lock_lost` stays 1.
- **`soft_rst` in RUN**: with `lock_lost`=1, pulse `soft_rst` for 1 cycle → next edge `ch_en`=00, `lock_lost`=0; re-release with identical timing.
- **Simultaneous events**: `soft_rst` on the same edge the FSM sees `lock_s`=0 → `lock_lost`=1, state 0.
- **Parameter sweep**: `NUM_CH`=4, `STAGGER`=1, `RST_HOLD`=1 → enables on 4 consecutive edges; `ready` 4 edges after `ch_en[0]`; assert ordering invariants every cycle.
